// File: rtl/snake_tile_map_if.sv
// Segment-stream and tile-query bus for snake_tile_map.
//   seg_vld/seg_x/seg_y/seg_end : segment beats from the move block (master -> slave)
//   seg_ready                   : level permission for the move block to emit beats
//   rd_x/rd_y                   : renderer tile query (master -> slave)
//   rd_body/rd_head             : registered query answers (slave -> master)
interface snake_tile_map_if #(
  parameter int unsigned H_LOGIC_WIDTH = 5,
  parameter int unsigned V_LOGIC_WIDTH = 5
);
  logic                     seg_vld;
  logic [H_LOGIC_WIDTH-1:0] seg_x;
  logic [V_LOGIC_WIDTH-1:0] seg_y;
  logic                     seg_end;
  logic                     seg_ready;
  logic [H_LOGIC_WIDTH-1:0] rd_x;
  logic [V_LOGIC_WIDTH-1:0] rd_y;
  logic                     rd_body;
  logic                     rd_head;

  modport master (
    output seg_vld, seg_x, seg_y, seg_end, rd_x, rd_y,
    input  seg_ready, rd_body, rd_head
  );

  modport slave (
    input  seg_vld, seg_x, seg_y, seg_end, rd_x, rd_y,
    output seg_ready, rd_body, rd_head
  );
endinterface

// File: rtl/snake_tile_map.sv
// Double-buffered snake occupancy bitmap.
// Per game tick the write bank is cleared row by row, then painted from the
// segment stream; the finished bank becomes the display bank at the next
// vblank (frame_sync). Renderer queries always read the display bank.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   frame_start  : game-tick pulse; starts (or restarts) a frame
//   frame_sync   : display vblank pulse; bank swap point
//   bus          : segment stream + tile query (snake_tile_map_if.slave)
//   frame_len    : body cells painted in the last committed frame
//   swap_done    : one-cycle pulse on bank swap
//   overrun      : sticky, frame_start arrived before the frame committed
module snake_tile_map #(
  parameter int unsigned H_LOGIC_MAX   = 31,
  parameter int unsigned V_LOGIC_MAX   = 23,
  parameter int unsigned H_LOGIC_WIDTH = 5,
  parameter int unsigned V_LOGIC_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  frame_sync,
  snake_tile_map_if.slave       bus,
  output logic [9:0]            frame_len,
  output logic                  swap_done,
  output logic                  overrun
);

  typedef logic [H_LOGIC_MAX:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    COLLECT,
    COMMIT
  } state_t;

  localparam logic [V_LOGIC_WIDTH-1:0] LAST_ROW = V_LOGIC_WIDTH'(V_LOGIC_MAX);

  state_t                   state;
  logic                     wr_bank;
  logic [V_LOGIC_WIDTH-1:0] clr_row;
  logic [9:0]               seg_cnt;
  logic [H_LOGIC_WIDTH-1:0] wr_head_x;
  logic [V_LOGIC_WIDTH-1:0] wr_head_y;
  logic [H_LOGIC_WIDTH-1:0] disp_head_x;
  logic [V_LOGIC_WIDTH-1:0] disp_head_y;

  // wr_bank selects the bank being built; the other one is on display.
  row_t bank0 [V_LOGIC_MAX+1];
  row_t bank1 [V_LOGIC_MAX+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_bank       <= 1'b0;
      clr_row       <= '0;
      seg_cnt       <= '0;
      wr_head_x     <= H_LOGIC_WIDTH'(1);
      wr_head_y     <= '0;
      disp_head_x   <= H_LOGIC_WIDTH'(1);
      disp_head_y   <= '0;
      bus.seg_ready <= 1'b0;
      bus.rd_body   <= 1'b0;
      bus.rd_head   <= 1'b0;
      frame_len     <= '0;
      swap_done     <= 1'b0;
      overrun       <= 1'b0;
      for (int unsigned r = 0; r <= V_LOGIC_MAX; r++) begin
        bank0[V_LOGIC_WIDTH'(r)] <= '0;
        bank1[V_LOGIC_WIDTH'(r)] <= '0;
      end
    end else begin
      swap_done <= 1'b0;

      // Read port sees the pre-edge wr_bank, so a query in the swap cycle
      // still returns the old display bank.
      if (bus.rd_y <= LAST_ROW) begin
        bus.rd_body <= wr_bank ? bank0[bus.rd_y][bus.rd_x] : bank1[bus.rd_y][bus.rd_x];
      end else begin
        bus.rd_body <= 1'b0;
      end
      bus.rd_head <= (bus.rd_x == disp_head_x) && (bus.rd_y == disp_head_y);

      if (frame_start) begin
        // A tick outside IDLE abandons the partial frame; this takes
        // priority over a coincident end beat or frame_sync.
        if (state != IDLE) begin
          overrun <= 1'b1;
        end
        state         <= CLEAR;
        clr_row       <= '0;
        seg_cnt       <= '0;
        bus.seg_ready <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          CLEAR: begin
            // Upstream presents the new head on the cycle after the tick.
            if (clr_row == '0) begin
              wr_head_x <= bus.seg_x;
              wr_head_y <= bus.seg_y;
            end
            if (wr_bank) begin
              bank1[clr_row] <= '0;
            end else begin
              bank0[clr_row] <= '0;
            end
            if (clr_row == LAST_ROW) begin
              state         <= COLLECT;
              bus.seg_ready <= 1'b1;
            end else begin
              clr_row <= clr_row + 1'b1;
            end
          end
          COLLECT: begin
            if (bus.seg_vld) begin
              if (bus.seg_end) begin
                state         <= COMMIT;
                bus.seg_ready <= 1'b0;
              end else if (bus.seg_y <= LAST_ROW) begin
                if (wr_bank) begin
                  bank1[bus.seg_y][bus.seg_x] <= 1'b1;
                end else begin
                  bank0[bus.seg_y][bus.seg_x] <= 1'b1;
                end
                if (seg_cnt != '1) begin
                  seg_cnt <= seg_cnt + 10'd1;
                end
              end
            end
          end
          COMMIT: begin
            if (frame_sync) begin
              wr_bank     <= ~wr_bank;
              disp_head_x <= wr_head_x;
              disp_head_y <= wr_head_y;
              frame_len   <= seg_cnt;
              swap_done   <= 1'b1;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
